spi_flash_read_master: RTL and testbench
========================================

Name: spi_flash_read_master

Overview:
- On-chip SPI mode-0 master that fetches a block of bytes from the off-chip serial flash using the READ command (0x03, 24-bit address, MSB first).
- Drives SCK/CSbar/DI toward the flash and samples the flash's DO line.
- Delivers received bytes one at a time to the boot/loader logic through a valid strobe.
- Sits directly upstream of the off-chip flash model and replaces any bench-driven SPI stimulus.

Parameters:
- CLK_DIV, 2, clk cycles per SCK half-period (≥1).
- CS_GAP, 8, clk cycles CSbar is held high after a transfer before done and return to idle (≥4, so the flash sees the CS rising edge).
- LEN_W, 16, width of the byte-count input.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- addr  in  24  flash byte address; latched on accepted start.
- len  in  LEN_W  number of bytes to read; latched on accepted start.
- SCK  out  1  SPI clock; idles low.
- CSbar  out  1  flash chip select, active low; idles high.
- DI  out  1  MOSI to the flash.
- DO  in  1  MISO from the flash.
- data_out  out  8  last received byte, MSB-first assembled.
- data_valid  out  1  one-cycle strobe; data_out is new.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of transfer.

Behaviour:
- Reset values: SCK=0, CSbar=1, DI=0, data_out=0, data_valid=0, busy=0, done=0, FSM=IDLE. Reset is asynchronous, so assertion mid-transfer returns all outputs to these values immediately. No partial byte is reported.
- Start acceptance:
  - start is accepted only in IDLE with len≠0.
  - start with len=0 is ignored: no busy, no done.
  - start while busy is ignored.
- Shift register: 32-bit TX register {8'h03, addr}, shifted MSB first.
- Half-period timer: SCK toggles only when the timer reaches CLK_DIV-1, then reloads.
- FSM states:
  - IDLE: on accepted start, latch addr/len, set busy=1, CSbar=0, DI=bit31 (0), go SETUP.
  - SETUP: SCK stays low for one half-period, then go CMD.
  - CMD: 32 SCK cycles.
    - Each SCK rising edge is where the flash samples DI.
    - On each SCK falling edge, DI advances to the next TX bit.
    - After the 32nd rising edge, hold DI=0 and go DATA on that falling edge.
  - DATA: 8·len SCK cycles.
    - DO is sampled on the clk edge that raises SCK; it has been stable one half-period since the flash drove it on the previous falling edge.
    - Bits shift into an 8-bit RX register, MSB first.
    - After the 8th bit of a byte, data_out is updated and data_valid is pulsed on the next clk.
    - The byte counter decrements. When it reaches 0, go END at the next falling edge.
  - END: SCK low for one half-period, then CSbar=1, go GAP.
  - GAP: hold CSbar=1 for CS_GAP clks, then pulse done=1 and set busy=0 in the same cycle, go IDLE.
- SCK is never high while CSbar is high.
- Exactly 32+8·len rising SCK edges occur per transfer.
- data_valid never coincides with done.
- Wrap-around of reads inside a flash sector is the flash's concern; the master streams blindly for len bytes.
- Timing with CLK_DIV=2: one SCK period = 4 clk.
  - CSbar falls 1 clk after start.
  - First data byte strobe ≈ 1 + 2 + 40·4 clk after start.

Test Plan:
- Flash memory = 11 22 33 44; start, addr=0, len=4 -> DI stream on rising SCK = 0x03000000; data_valid ×4 with data_out 0x11, 0x22, 0x33, 0x44; one done; 64 SCK rising edges.
- Same memory, len=6, addr=0 -> bytes 11 22 33 44 11 22 (flash sector wrap with depth 4); CSbar low throughout, one done.
- addr=0x00A5C3, len=1 -> DI captures exactly 0x0300A5C3 MSB first; SCK low whenever CSbar high.
- start with len=0 -> busy stays 0, CSbar stays 1, no done. start pulsed again while busy -> ignored, single done.
- rst_n low at the 10th DATA bit -> CSbar=1, SCK=0, busy=0 immediately, no data_valid. A new start after release reads correct bytes from byte 0.
- CLK_DIV=1 and CLK_DIV=5 with len=2 -> same data bytes; SCK high time = CLK_DIV clk; CSbar high ≥ CS_GAP clk before done.

Source files
------------

// File: rtl/spi_flash_read_master_if.sv
// Boot-side request/response signals plus the SPI pins of the flash read master.
interface spi_flash_read_master_if #(
  parameter int unsigned LEN_W = 16
);
  logic             start;
  logic [23:0]      addr;
  logic [LEN_W-1:0] len;
  logic             SCK;
  logic             CSbar;
  logic             DI;
  logic             DO;
  logic [7:0]       data_out;
  logic             data_valid;
  logic             busy;
  logic             done;

  modport master (
    input  start, addr, len, DO,
    output SCK, CSbar, DI, data_out, data_valid, busy, done
  );

  modport slave (
    output start, addr, len, DO,
    input  SCK, CSbar, DI, data_out, data_valid, busy, done
  );
endinterface

// File: rtl/spi_flash_read_master.sv
// SPI mode-0 master issuing READ (0x03 + 24-bit address) and streaming len bytes
// back to the loader one strobe per byte.
module spi_flash_read_master #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 8,
  parameter int unsigned LEN_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  spi_flash_read_master_if.master bus
);

  localparam int unsigned TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GW = $clog2(CS_GAP + 1);
  localparam logic [7:0] CMD_READ = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CMD, S_DATA, S_END, S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [31:0]      tx_q, tx_d;
  logic [6:0]       rx_q, rx_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             sck_q, sck_d;
  logic             cs_n_q, cs_n_d;
  logic             di_q, di_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick;

  assign tick = (timer_q == TW'(CLK_DIV - 1));

  // Next-state: every SCK edge happens on a half-period tick.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    gap_d      = gap_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    sck_d      = sck_q;
    cs_n_d     = cs_n_q;
    di_d       = di_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (state_q inside {S_SETUP, S_CMD, S_DATA, S_END}) begin
      timer_d = tick ? '0 : timer_q + TW'(1);
    end

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (bus.start && (bus.len != '0)) begin
          state_d    = S_SETUP;
          tx_d       = {CMD_READ, bus.addr};
          byte_cnt_d = bus.len;
          bit_cnt_d  = '0;
          busy_d     = 1'b1;
          cs_n_d     = 1'b0;
          di_d       = CMD_READ[7];
        end
      end
      S_SETUP: begin
        if (tick) begin
          sck_d   = 1'b1;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (tick) begin
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d     = 1'b0;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd31) begin
              di_d      = 1'b0;
              bit_cnt_d = '0;
              state_d   = S_DATA;
            end else begin
              tx_d = {tx_q[30:0], tx_q[31]};
              di_d = tx_q[30];
            end
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (!sck_q) begin
            // DO has been stable since the previous falling edge.
            sck_d     = 1'b1;
            rx_d      = {rx_q[5:0], bus.DO};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d  = '0;
              data_out_d = {rx_q, bus.DO};
              valid_d    = 1'b1;
              byte_cnt_d = byte_cnt_q - LEN_W'(1);
            end
          end else begin
            sck_d = 1'b0;
            if (byte_cnt_q == '0) state_d = S_END;
          end
        end
      end
      S_END: begin
        if (tick) begin
          cs_n_d  = 1'b1;
          gap_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GW'(CS_GAP - 1)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      gap_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      sck_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      di_q       <= 1'b0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      gap_q      <= gap_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      sck_q      <= sck_d;
      cs_n_q     <= cs_n_d;
      di_q       <= di_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.SCK        = sck_q;
  assign bus.CSbar      = cs_n_q;
  assign bus.DI         = di_q;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_spi_flash_read_master.sv
// Bench: three masters (CLK_DIV 2/1/5), each with a 4-byte wrapping flash model and pin monitor.
module tb_spi_flash_read_master;

  typedef struct packed {
    int          ndone;
    int          nvalid;
    int          rises;
    int          ncsr;
    int          err;
    int          hierr;
    logic [31:0] cmd;
    logic        busy;
    logic        cs;
  } mon_t;

  typedef struct {
    logic [23:0] addr;
    logic [15:0] len;
    logic [7:0]  b0;
    logic [7:0]  blast;
    int          rises;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        start_v [3];
  logic [23:0] addr_v  [3];
  logic [15:0] len_v   [3];
  mon_t        mon_a   [3];
  logic [7:0]  flash_mem [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int unsigned DIV = (g == 0) ? 2 : ((g == 1) ? 1 : 5);

    spi_flash_read_master_if #(.LEN_W(16)) bus ();

    spi_flash_read_master #(.CLK_DIV(DIV), .CS_GAP(8), .LEN_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
    );

    assign bus.start = start_v[g];
    assign bus.addr  = addr_v[g];
    assign bus.len   = len_v[g];

    int          rise = 0, rises = 0, nvalid = 0, ndone = 0, ncsr = 0;
    int          err = 0, hierr = 0, hi_run = 0, cs_run = 0, k;
    logic [31:0] cmd = '0;
    logic [1:0]  ix;
    logic        prev_sck = 1'b0, prev_cs = 1'b1;
    logic [7:0]  blog [0:511];

    assign mon_a[g] = '{ndone, nvalid, rises, ncsr, err, hierr, cmd, bus.busy, bus.CSbar};

    // Flash model and pin monitor, evaluated mid-cycle.
    always @(negedge clk) begin
      if (prev_cs && !bus.CSbar) begin rise = 0; cmd = '0; end
      if (!prev_cs && bus.CSbar) ncsr++;
      if (bus.CSbar) bus.DO = 1'b0;
      if (bus.SCK && !prev_sck) begin
        rises++;
        if (rise < 32) cmd = {cmd[30:0], bus.DI};
        rise++;
      end
      if (!bus.SCK && prev_sck && !bus.CSbar && rise >= 32) begin
        k = rise - 32;
        ix = cmd[1:0] + 2'(k / 8);
        bus.DO = flash_mem[ix][3'(7 - k % 8)];
      end
      if (bus.SCK) hi_run++;
      else begin
        if (prev_sck && hi_run != int'(DIV)) hierr++;
        hi_run = 0;
      end
      if (bus.SCK && bus.CSbar) err++;
      if (bus.CSbar) cs_run++; else cs_run = 0;
      if (bus.data_valid) begin
        blog[nvalid] = bus.data_out;
        nvalid++;
        if (bus.done) err++;
      end
      if (bus.done) begin
        ndone++;
        if (bus.busy || cs_run < 8) err++;
      end
      prev_sck = bus.SCK;
      prev_cs  = bus.CSbar;
    end
  end

  function automatic logic [7:0] mon_byte(input int i, input int n);
    case (i)
      0:       return u[0].blog[n];
      1:       return u[1].blog[n];
      default: return u[2].blog[n];
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input int i, input logic [23:0] a, input logic [15:0] l);
    @(negedge clk);
    addr_v[i] = a; len_v[i] = l; start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int base, input int budget);
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (mon_a[i].ndone != base) begin ok = 1'b1; break; end
    end
    chk("done_within_budget", 32'(ok), 32'd1);
  endtask

  // One complete read checked against the flash contents and pin-level rules.
  task automatic xfer(input int i, input logic [23:0] a, input logic [15:0] l);
    mon_t s0;
    s0 = mon_a[i];
    pulse_start(i, a, l);
    chk("busy_after_start", 32'(mon_a[i].busy), 32'd1);
    chk("csbar_after_start", 32'(mon_a[i].cs), 32'd0);
    wait_done(i, s0.ndone, (40 + 8 * int'(l)) * 12 + 60);
    repeat (4) @(negedge clk);
    chk("done_count", mon_a[i].ndone - s0.ndone, 32'd1);
    chk("valid_count", mon_a[i].nvalid - s0.nvalid, 32'(l));
    chk("sck_rises", mon_a[i].rises - s0.rises, 32'(32 + 8 * int'(l)));
    chk("csbar_rises", mon_a[i].ncsr - s0.ncsr, 32'd1);
    chk("di_command", mon_a[i].cmd, {8'h03, a});
    for (int n = 0; n < int'(l); n++)
      chk("data_byte", 32'(mon_byte(i, s0.nvalid + n)), 32'(flash_mem[2'(int'(a) + n)]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [4];
    mon_t s0;
    bit   bad;
    int   nv;

    tbl[0] = '{24'h000000, 16'd4, 8'h11, 8'h44, 64};
    tbl[1] = '{24'h000000, 16'd6, 8'h11, 8'h22, 80};
    tbl[2] = '{24'h00A5C3, 16'd1, 8'h44, 8'h44, 40};
    tbl[3] = '{24'h000002, 16'd3, 8'h33, 8'h11, 56};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin start_v[i] = 1'b0; addr_v[i] = '0; len_v[i] = '0; end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sck", 32'(u[0].bus.SCK), 32'd0);
    chk("rst_csbar", 32'(u[0].bus.CSbar), 32'd1);
    chk("rst_di", 32'(u[0].bus.DI), 32'd0);
    chk("rst_data_out", 32'(u[0].bus.data_out), 32'd0);
    chk("rst_valid", 32'(u[0].bus.data_valid), 32'd0);
    chk("rst_busy", 32'(u[0].bus.busy), 32'd0);
    chk("rst_done", 32'(u[0].bus.done), 32'd0);

    for (int t = 0; t < 4; t++) begin
      s0 = mon_a[0];
      xfer(0, tbl[t].addr, tbl[t].len);
      chk("tbl_first_byte", 32'(mon_byte(0, s0.nvalid)), 32'(tbl[t].b0));
      chk("tbl_last_byte", 32'(mon_byte(0, s0.nvalid + int'(tbl[t].len) - 1)), 32'(tbl[t].blast));
      chk("tbl_rises", mon_a[0].rises - s0.rises, 32'(tbl[t].rises));
    end

    // len = 0 must be ignored entirely.
    s0 = mon_a[0];
    pulse_start(0, 24'h000001, 16'd0);
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (mon_a[0].busy || !mon_a[0].cs) bad = 1'b1;
    end
    chk("len0_idle", 32'(bad), 32'd0);
    chk("len0_no_done", mon_a[0].ndone - s0.ndone, 32'd0);

    // A second start while busy is dropped, not queued.
    s0 = mon_a[0];
    pulse_start(0, 24'h000001, 16'd2);
    repeat (60) @(negedge clk);
    pulse_start(0, 24'h000003, 16'd1);
    wait_done(0, s0.ndone, 2000);
    repeat (150) @(negedge clk);
    chk("busy_start_done", mon_a[0].ndone - s0.ndone, 32'd1);
    chk("busy_start_valid", mon_a[0].nvalid - s0.nvalid, 32'd2);
    chk("busy_start_cmd", mon_a[0].cmd, 32'h03000001);
    chk("busy_start_b0", 32'(mon_byte(0, s0.nvalid)), 32'h22);
    chk("busy_start_b1", 32'(mon_byte(0, s0.nvalid + 1)), 32'h33);

    // Reset at the 10th data bit; byte 0 has already been delivered.
    s0 = mon_a[0];
    pulse_start(0, 24'h000000, 16'd4);
    bad = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (mon_a[0].rises - s0.rises >= 42) begin bad = 1'b0; break; end
    end
    chk("reach_data_bit10", 32'(bad), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_csbar", 32'(u[0].bus.CSbar), 32'd1);
    chk("midrst_sck", 32'(u[0].bus.SCK), 32'd0);
    chk("midrst_busy", 32'(u[0].bus.busy), 32'd0);
    chk("midrst_valid", 32'(u[0].bus.data_valid), 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_valid_count", mon_a[0].nvalid - s0.nvalid, 32'd1);
    chk("midrst_no_done", mon_a[0].ndone - s0.ndone, 32'd0);
    xfer(0, 24'h000000, 16'd4);

    // Other divider settings.
    xfer(1, 24'h000000, 16'd2);
    xfer(2, 24'h000000, 16'd2);
    chk("div1_sck_high", mon_a[1].hierr, 32'd0);
    chk("div5_sck_high", mon_a[2].hierr, 32'd0);

    for (int r = 0; r < 6; r++)
      xfer(0, 24'($urandom), 16'($urandom_range(1, 5)));

    for (int i = 0; i < 3; i++) chk("pin_rules", mon_a[i].err, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
